// File: rtl/binary_add_pipe.sv
// Pipelined, carry-segmented unsigned adder/subtractor with valid strobe and global stall.
// Optional build macro BINADD_SAT_EN: final stage clamps on overflow/borrow.
module binary_add_pipe #(
    parameter int unsigned WIDTH  = 15,
    parameter int unsigned STAGES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             in_valid,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] S,
    output logic             cout,
    output logic             out_valid
);

    localparam int unsigned SEG = (WIDTH + STAGES - 1) / STAGES;

    // Chain index k = values entering stage k; index STAGES = final registered outputs.
    logic [WIDTH-1:0] w_a   [STAGES];
    logic [WIDTH-1:0] w_b   [STAGES];
    logic [WIDTH-1:0] w_s   [STAGES+1];
    logic             w_c   [STAGES+1];
    logic             w_vld [STAGES+1];
`ifdef BINADD_SAT_EN
    logic             w_sub [STAGES];
`endif

    // Subtract is A + ~B + 1: invert B once at entry and seed the carry chain with sub.
    assign w_a[0]   = A;
    assign w_b[0]   = sub ? ~B : B;
    assign w_s[0]   = '0;
    assign w_c[0]   = sub;
    assign w_vld[0] = in_valid;
`ifdef BINADD_SAT_EN
    assign w_sub[0] = sub;
`endif

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int unsigned LO = k * SEG;
        localparam int unsigned HI = ((k + 1) * SEG < WIDTH) ? (k + 1) * SEG : WIDTH;
        localparam int unsigned SL = (LO < WIDTH) ? (HI - LO) : 0;

        logic [WIDTH-1:0] w_s_nxt;
        logic             w_c_nxt;
        logic [WIDTH-1:0] w_s_fin;
        logic [WIDTH-1:0] r_s;
        logic             r_c;
        logic             r_vld;

        if (SL > 0) begin : g_add
            localparam int unsigned SLW = SL + 1;
            logic [SL:0] w_slice;

            assign w_slice = SLW'(SL'(w_a[k] >> LO)) + SLW'(SL'(w_b[k] >> LO)) + SLW'(w_c[k]);

            // Lower slices arrive already computed; only this stage's slice is filled in.
            always_comb begin
                w_s_nxt             = w_s[k];
                w_s_nxt[LO +: SL]   = w_slice[SL-1:0];
            end
            assign w_c_nxt = w_slice[SL];
        end else begin : g_pass
            assign w_s_nxt = w_s[k];
            assign w_c_nxt = w_c[k];
        end

        if (k == STAGES - 1) begin : g_last
`ifdef BINADD_SAT_EN
            // Clamp: add overflow -> all-ones, subtract borrow -> zero; cout stays raw.
            always_comb begin
                w_s_fin = w_s_nxt;
                if (w_sub[k] && !w_c_nxt) begin
                    w_s_fin = '0;
                end else if (!w_sub[k] && w_c_nxt) begin
                    w_s_fin = '1;
                end
            end
`else
            assign w_s_fin = w_s_nxt;
`endif
        end else begin : g_mid
            assign w_s_fin = w_s_nxt;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_s   <= '0;
                r_c   <= 1'b0;
                r_vld <= 1'b0;
            end else if (en) begin
                r_s   <= w_s_fin;
                r_c   <= w_c_nxt;
                r_vld <= w_vld[k];
            end
        end

        assign w_s[k+1]   = r_s;
        assign w_c[k+1]   = r_c;
        assign w_vld[k+1] = r_vld;

        // Operands (and sub for the clamp) travel alongside their carry.
        if (k < STAGES - 1) begin : g_fwd
            logic [WIDTH-1:0] r_a;
            logic [WIDTH-1:0] r_b;
`ifdef BINADD_SAT_EN
            logic             r_sub;
`endif
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_a   <= '0;
                    r_b   <= '0;
`ifdef BINADD_SAT_EN
                    r_sub <= 1'b0;
`endif
                end else if (en) begin
                    r_a   <= w_a[k];
                    r_b   <= w_b[k];
`ifdef BINADD_SAT_EN
                    r_sub <= w_sub[k];
`endif
                end
            end
            assign w_a[k+1] = r_a;
            assign w_b[k+1] = r_b;
`ifdef BINADD_SAT_EN
            assign w_sub[k+1] = r_sub;
`endif
        end
    end

    assign S         = w_s[STAGES];
    assign cout      = w_c[STAGES];
    assign out_valid = w_vld[STAGES];

endmodule
